boot_rom_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port SoC boot ROM between `NB_MASTERS` requesters, such as the FC instruction port and the debug/system-bus port. It sits between the SoC interconnect request ports and the boot ROM's chip-select/address/read-data port. It accepts one TCDM-style request per cycle and drives the ROM's 1-cycle read. It routes the read data back with `r_valid` to the granted master. Write attempts are rejected with an error response and never reach the ROM.

---
 rtl/boot_rom_arbiter.sv | 111 +++++++++++
 tb/tb_boot_rom_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/boot_rom_arbiter.sv
// boot_rom_arbiter
//   Shares the single-port boot ROM between NB_MASTERS TCDM-style requesters.
//   Each cycle it grants at most one requester, chosen round-robin. A granted
//   read drives the ROM chip-select and word address. A granted write is
//   rejected without touching the ROM. The response comes back one cycle
//   later: r_valid_o goes to the granted master, r_opc_o flags a rejected write.
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   req_i/add_i/wen_i   per-master request, byte address, write-enable (1 = read)
//   gnt_o               per-master grant, combinational, one-hot or zero
//   r_valid_o           per-master response valid, one cycle after the grant
//   r_rdata_o, r_opc_o  shared response data and error flag
//   rom_csn_o/rom_add_o ROM chip select (active-low) and word address
//   rom_rdata_i         ROM read data, valid the cycle after rom_csn_o = 0
module boot_rom_arbiter #(
  parameter int NB_MASTERS     = 2,
  parameter int ROM_ADDR_WIDTH = 13
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NB_MASTERS-1:0]         req_i,
  input  logic [NB_MASTERS-1:0][31:0]   add_i,
  input  logic [NB_MASTERS-1:0]         wen_i,
  output logic [NB_MASTERS-1:0]         gnt_o,
  output logic [NB_MASTERS-1:0]         r_valid_o,
  output logic [31:0]                   r_rdata_o,
  output logic                          r_opc_o,
  output logic                          rom_csn_o,
  output logic [ROM_ADDR_WIDTH-3:0]     rom_add_o,
  input  logic [31:0]                   rom_rdata_i
);

  localparam int                IDX_W = $clog2(NB_MASTERS);
  localparam logic [IDX_W:0]    NB_L  = (IDX_W+1)'(NB_MASTERS);
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(NB_MASTERS-1);
  localparam logic [NB_MASTERS-1:0] ONE = NB_MASTERS'(1);

  logic [IDX_W-1:0]          rr_q;
  logic [IDX_W-1:0]          rr_next;
  logic [IDX_W-1:0]          win_idx;
  logic                      win_vld;
  logic [IDX_W:0]            cand;
  logic                      grant_any;
  logic                      win_wen;
  logic                      rd_grant;
  logic [ROM_ADDR_WIDTH-3:0] rom_add_q;
  logic [ROM_ADDR_WIDTH-3:0] win_add;

  logic                      rsp_valid_q;
  logic [IDX_W-1:0]          rsp_idx_q;
  logic                      rsp_err_q;

  // Only the word-index bits of the address matter; the rest is decoded upstream.
  logic unused_add_bits;
  assign unused_add_bits = ^add_i;

  // Round-robin search starting at rr_q, wrapping at NB_MASTERS.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < NB_MASTERS; i++) begin
      cand = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (cand >= NB_L) cand = cand - NB_L;
      if (!win_vld && req_i[cand[IDX_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
  end

  // Grants are suppressed while reset is held, independent of req_i.
  assign grant_any = rst_ni & win_vld;
  assign win_wen   = wen_i[win_idx];
  assign rd_grant  = grant_any & win_wen;
  assign win_add   = add_i[win_idx][ROM_ADDR_WIDTH-1:2];
  assign gnt_o     = grant_any ? (ONE << win_idx) : '0;
  assign rr_next   = (win_idx == LAST) ? '0 : win_idx + 1'b1;

  // Rejected writes keep chip select high. The address output only moves on
  // a real read, so the ROM address pins do not toggle needlessly.
  assign rom_csn_o = ~rd_grant;
  assign rom_add_o = rd_grant ? win_add : rom_add_q;

  // Stage boundary: grant cycle -> response cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_err_q   <= 1'b0;
      rom_add_q   <= '0;
    end else begin
      rsp_valid_q <= grant_any;
      rsp_idx_q   <= win_idx;
      rsp_err_q   <= grant_any & ~win_wen;
      if (grant_any) rr_q <= rr_next;
      if (rd_grant)  rom_add_q <= win_add;
    end
  end

  always_comb begin
    r_valid_o = '0;
    if (rsp_valid_q) r_valid_o = ONE << rsp_idx_q;
  end

  assign r_rdata_o = (rsp_valid_q && !rsp_err_q) ? rom_rdata_i : 32'h0;
  assign r_opc_o   = rsp_valid_q & rsp_err_q;

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Testbench for boot_rom_arbiter. It drives a 2-master instance and a 4-master
// instance, each attached to a small behavioural ROM. Directed steps check the
// grant-cycle outputs directly and push the expected response into a
// per-instance queue. Separate monitors pop the queue and compare on every cycle.
module tb_boot_rom_arbiter;

  typedef struct {
    int          cyc;
    logic [7:0]  vld;
    logic [31:0] data;
    logic        opc;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 2-master instance
  logic [1:0]        req2 = '0, wen2 = '1, gnt2, rv2;
  logic [1:0][31:0]  add2 = '0;
  logic [31:0]       rdata2, rd2 = '0;
  logic              opc2, csn2;
  logic [10:0]       radd2;
  logic [10:0]       exp_add2 = '0;
  rsp_t              q2[$];

  // 4-master instance
  logic [3:0]        req4 = '0, wen4 = '1, gnt4, rv4;
  logic [3:0][31:0]  add4;
  logic [31:0]       rdata4, rd4 = '0;
  logic              opc4, csn4;
  logic [10:0]       radd4;
  logic [10:0]       exp_add4 = '0;
  rsp_t              q4[$];

  boot_rom_arbiter #(.NB_MASTERS(2), .ROM_ADDR_WIDTH(13)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .add_i(add2), .wen_i(wen2),
    .gnt_o(gnt2), .r_valid_o(rv2), .r_rdata_o(rdata2), .r_opc_o(opc2),
    .rom_csn_o(csn2), .rom_add_o(radd2), .rom_rdata_i(rd2));

  boot_rom_arbiter #(.NB_MASTERS(4), .ROM_ADDR_WIDTH(13)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req4), .add_i(add4), .wen_i(wen4),
    .gnt_o(gnt4), .r_valid_o(rv4), .r_rdata_o(rdata4), .r_opc_o(opc4),
    .rom_csn_o(csn4), .rom_add_o(radd4), .rom_rdata_i(rd4));

  // ROM contents: word 0x21 holds 0xDEADBEEF, every other word holds B007_<word>.
  function automatic logic [31:0] rom_word(input logic [10:0] w);
    if (w == 11'h021) return 32'hDEADBEEF;
    return {16'hB007, 5'b0, w};
  endfunction

  always @(posedge clk) begin
    if (!csn2) rd2 <= rom_word(radd2);
    if (!csn4) rd4 <= rom_word(radd4);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Response monitors
  always @(negedge clk) begin
    rsp_t e;
    if (q2.size() > 0 && q2[0].cyc == cyc) begin
      e = q2.pop_front();
      chk("rsp2_valid", 32'(rv2), 32'(e.vld));
      chk("rsp2_rdata", rdata2, e.data);
      chk("rsp2_opc", 32'(opc2), 32'(e.opc));
    end else if (rv2 != 2'b00 || opc2) begin
      chk("rsp2_unexpected", {29'b0, opc2, rv2}, 32'h0);
    end
  end

  always @(negedge clk) begin
    rsp_t e;
    if (q4.size() > 0 && q4[0].cyc == cyc) begin
      e = q4.pop_front();
      chk("rsp4_valid", 32'(rv4), 32'(e.vld));
      chk("rsp4_rdata", rdata4, e.data);
      chk("rsp4_opc", 32'(opc4), 32'(e.opc));
    end else if (rv4 != 4'b0000 || opc4) begin
      chk("rsp4_unexpected", {27'b0, opc4, rv4}, 32'h0);
    end
  end

  // One request cycle on the 2-master instance. eg is the hand-derived grant.
  task automatic step2(input logic [1:0] req, input logic [1:0] wen,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [1:0] eg, input bit push, input string nm);
    int   k;
    logic rd;
    rsp_t e;
    @(posedge clk); #1;
    req2 = req; wen2 = wen; add2[0] = a0; add2[1] = a1;
    @(negedge clk);
    chk({nm, "_gnt"}, 32'(gnt2), 32'(eg));
    k  = eg[1] ? 1 : 0;
    rd = (eg != 2'b00) && wen[k];
    if (rd) exp_add2 = k ? a1[12:2] : a0[12:2];
    chk({nm, "_csn"}, 32'(csn2), 32'(!rd));
    chk({nm, "_romadd"}, 32'(radd2), 32'(exp_add2));
    if (eg != 2'b00 && push) begin
      e.cyc = cyc + 1; e.vld = 8'(eg);
      e.data = rd ? rom_word(exp_add2) : 32'h0; e.opc = !rd;
      q2.push_back(e);
    end
  endtask

  // One read-request cycle on the 4-master instance; master k reads word 0x10+k.
  task automatic step4(input logic [3:0] req, input logic [3:0] eg, input string nm);
    int   k;
    rsp_t e;
    @(posedge clk); #1;
    req4 = req;
    @(negedge clk);
    chk({nm, "_gnt"}, 32'(gnt4), 32'(eg));
    k = 0;
    for (int i = 0; i < 4; i++) if (eg[i]) k = i;
    if (eg != 4'b0) exp_add4 = 11'(16 + k);
    chk({nm, "_csn"}, 32'(csn4), 32'(eg == 4'b0));
    chk({nm, "_romadd"}, 32'(radd4), 32'(exp_add4));
    if (eg != 4'b0) begin
      e.cyc = cyc + 1; e.vld = 8'(eg); e.data = rom_word(exp_add4); e.opc = 1'b0;
      q4.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req2 = '0; req4 = '0;
    @(negedge clk);
    rst_n = 1'b1; exp_add2 = '0; exp_add4 = '0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) add4[i] = 32'h1A000040 + 32'(4 * i);

    // Reset state with every master requesting
    req2 = 2'b11; req4 = 4'hF;
    repeat (2) @(negedge clk);
    chk("rst_gnt2", 32'(gnt2), 32'h0);
    chk("rst_csn2", 32'(csn2), 32'h1);
    chk("rst_rvalid2", 32'(rv2), 32'h0);
    chk("rst_rdata2", rdata2, 32'h0);
    chk("rst_romadd2", 32'(radd2), 32'h0);
    chk("rst_gnt4", 32'(gnt4), 32'h0);
    chk("rst_csn4", 32'(csn4), 32'h1);
    req2 = '0; req4 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step2(2'b11, 2'b11, 32'h1A000000, 32'h1A000008, 2'b01, 1, "t1_first");

    // Single read from master 1, then rejected write from master 0
    step2(2'b10, 2'b11, 32'h1A000000, 32'h1A000084, 2'b10, 1, "t2_read");
    step2(2'b01, 2'b10, 32'h1A000010, 32'h1A000084, 2'b01, 1, "t4_write");
    step2(2'b00, 2'b11, 32'h0, 32'h0, 2'b00, 1, "idle_a");

    // Contention from reset, then mixed write/read, then a lone requester
    do_reset();
    step2(2'b11, 2'b11, 32'h1A000100, 32'h1A000204, 2'b01, 1, "t3_c0");
    step2(2'b11, 2'b11, 32'h1A000100, 32'h1A000204, 2'b10, 1, "t3_c1");
    step2(2'b11, 2'b11, 32'h1A000100, 32'h1A000204, 2'b01, 1, "t3_c2");
    step2(2'b11, 2'b11, 32'h1A000100, 32'h1A000204, 2'b10, 1, "t3_c3");
    step2(2'b11, 2'b01, 32'h1A000108, 32'h1A000204, 2'b01, 1, "mix_rd");
    step2(2'b11, 2'b01, 32'h1A000108, 32'h1A000204, 2'b10, 1, "mix_wr");
    step2(2'b01, 2'b11, 32'h1A00000C, 32'h0, 2'b01, 1, "solo0");
    step2(2'b01, 2'b11, 32'h1A000014, 32'h0, 2'b01, 1, "solo1");
    step2(2'b01, 2'b11, 32'h1A000084, 32'h0, 2'b01, 1, "solo2");
    step2(2'b00, 2'b11, 32'h0, 32'h0, 2'b00, 1, "idle_b");

    // Reset between grant and response drops the response
    step2(2'b10, 2'b11, 32'h1A000000, 32'h1A000030, 2'b10, 0, "t5_grant");
    rst_n = 1'b0; req2 = '0;
    @(negedge clk);
    chk("t5_rvalid_dropped", 32'(rv2), 32'h0);
    chk("t5_gnt_in_reset", 32'(gnt2), 32'h0);
    rst_n = 1'b1; exp_add2 = '0; exp_add4 = '0;
    step2(2'b11, 2'b11, 32'h1A000020, 32'h1A000030, 2'b01, 1, "t5_restart");
    step2(2'b00, 2'b11, 32'h0, 32'h0, 2'b00, 1, "idle_c");

    // Pointer wrap on four masters, then alternation between masters 1 and 3
    step4(4'b1111, 4'b0001, "t6_a0");
    step4(4'b1111, 4'b0010, "t6_a1");
    step4(4'b1111, 4'b0100, "t6_a2");
    step4(4'b1111, 4'b1000, "t6_a3");
    step4(4'b1111, 4'b0001, "t6_wrap");
    step4(4'b1010, 4'b0010, "t6_b1");
    step4(4'b1010, 4'b1000, "t6_b3");
    step4(4'b1010, 4'b0010, "t6_b1r");
    step4(4'b1010, 4'b1000, "t6_b3r");
    step4(4'b0000, 4'b0000, "idle_d");

    repeat (3) @(negedge clk);
    chk("q2_drained", 32'(q2.size()), 32'h0);
    chk("q4_drained", 32'(q4.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
